// File: rtl/qspi_ram_responder.sv
// Quad-SPI (mode 0) target bridging 0x02 write / 0x0B fast-read commands onto a byte-wide RAM port.
// All QSPI inputs are resynchronised into the system clock domain; SCK must run at most clock/4.
module qspi_ram_responder #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     qspi_clk,
  input  logic                     qspi_select,
  input  logic [3:0]               qspi_data_in,
  output logic [3:0]               qspi_data_out,
  output logic                     qspi_data_oe,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [7:0]               mem_rdata,
  output logic                     mem_re,
  output logic [7:0]               mem_wdata,
  output logic                     mem_we,
  output logic                     cmd_error
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, ERROR} state_t;

  state_t                   state;
  logic                     sck_s1, sck_s2, sck_prev;
  logic                     sel_s1, sel_s2, sel_prev;
  logic [3:0]               din_s1, din_s2;
  logic                     sck_rise, sck_fall, sel_fall;
  logic [7:0]               cnt;
  logic                     is_write;
  logic                     phase;
  logic [3:0]               cmd_hi;
  logic [3:0]               wr_hi;
  logic [3:0]               lo_nib;
  logic [ADDRESS_WIDTH-1:0] addr_sr;
  logic [ADDRESS_WIDTH+3:0] addr_shift;
  logic                     re_d;
  logic [7:0]               rbyte;

  assign sck_rise   = sck_s2 & ~sck_prev;
  assign sck_fall   = ~sck_s2 & sck_prev;
  assign sel_fall   = ~sel_s2 & sel_prev;
  assign addr_shift = {addr_sr, din_s2};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      sel_s1   <= 1'b1;
      sel_s2   <= 1'b1;
      sel_prev <= 1'b1;
      din_s1   <= 4'h0;
      din_s2   <= 4'h0;
    end else begin
      sck_s1   <= qspi_clk;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      sel_s1   <= qspi_select;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;
      din_s1   <= qspi_data_in;
      din_s2   <= din_s1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      qspi_data_out <= 4'h0;
      qspi_data_oe  <= 1'b0;
      mem_addr      <= '0;
      mem_re        <= 1'b0;
      mem_wdata     <= 8'h00;
      mem_we        <= 1'b0;
      cmd_error     <= 1'b0;
      cnt           <= 8'd0;
      is_write      <= 1'b0;
      phase         <= 1'b0;
      cmd_hi        <= 4'h0;
      wr_hi         <= 4'h0;
      lo_nib        <= 4'h0;
      addr_sr       <= '0;
      re_d          <= 1'b0;
      rbyte         <= 8'h00;
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      cmd_error <= 1'b0;
      re_d      <= mem_re;
      if (re_d) rbyte <= mem_rdata;
      // Select high wins over any SCK edge seen in the same clock; a half-assembled write byte is dropped.
      if (sel_s2 && state != IDLE) begin
        state        <= IDLE;
        qspi_data_oe <= 1'b0;
        cnt          <= 8'd0;
        phase        <= 1'b0;
      end else begin
        case (state)
          IDLE: if (sel_fall) begin
            state <= CMD;
            cnt   <= 8'd0;
          end
          CMD: if (sck_rise) begin
            cmd_hi <= din_s2;
            cnt    <= cnt + 8'd1;
            if (cnt == 8'd1) begin
              cnt <= 8'd0;
              if ({cmd_hi, din_s2} == 8'h02) begin
                is_write <= 1'b1;
                state    <= ADDR;
              end else if ({cmd_hi, din_s2} == 8'h0B) begin
                is_write <= 1'b0;
                state    <= ADDR;
              end else begin
                state     <= ERROR;
                cmd_error <= 1'b1;
              end
            end
          end
          ADDR: if (sck_rise) begin
            addr_sr <= addr_shift[ADDRESS_WIDTH-1:0];
            cnt     <= cnt + 8'd1;
            if (cnt == 8'd5) begin
              cnt      <= 8'd0;
              phase    <= 1'b0;
              mem_addr <= addr_shift[ADDRESS_WIDTH-1:0];
              if (is_write) begin
                state <= WRITE;
              end else begin
                state  <= DUMMY;
                mem_re <= 1'b1;
              end
            end
          end
          DUMMY: if (sck_rise) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(DUMMY_NIBBLES - 1)) begin
              cnt   <= 8'd0;
              phase <= 1'b0;
              state <= READ;
            end
          end
          READ: if (sck_fall) begin
            // High nibble goes out while the next byte is prefetched; its low nibble is parked in lo_nib.
            if (!phase) begin
              qspi_data_out <= rbyte[7:4];
              lo_nib        <= rbyte[3:0];
              qspi_data_oe  <= 1'b1;
              mem_addr      <= mem_addr + ADDRESS_WIDTH'(1);
              mem_re        <= 1'b1;
              phase         <= 1'b1;
            end else begin
              qspi_data_out <= lo_nib;
              phase         <= 1'b0;
            end
          end
          WRITE: begin
            if (mem_we) mem_addr <= mem_addr + ADDRESS_WIDTH'(1);
            if (sck_rise) begin
              if (!phase) begin
                wr_hi <= din_s2;
                phase <= 1'b1;
              end else begin
                mem_wdata <= {wr_hi, din_s2};
                mem_we    <= 1'b1;
                phase     <= 1'b0;
              end
            end
          end
          ERROR: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Randomised QSPI initiator and byte-RAM model checking the responder against an address-ordered reference memory.
module tb_qspi_ram_responder;

  localparam int AW    = 16;
  localparam int DN    = 2;
  localparam int HALF  = 5;

  typedef logic [7:0] byte_q_t[$];

  logic          clock = 1'b0;
  logic          reset;
  logic          qspi_clk;
  logic          qspi_select;
  logic [3:0]    qspi_data_in;
  logic [3:0]    qspi_data_out;
  logic          qspi_data_oe;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_re;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          cmd_error;

  int checks = 0;
  int errors = 0;

  bit   [7:0]    store   [65536];
  bit   [7:0]    ref_mem [65536];
  logic [AW-1:0] re_q[$];
  logic [AW-1:0] we_addr_q[$];
  logic [7:0]    we_dat_q[$];
  int            err_cnt  = 0;
  int            oe_cnt   = 0;
  int            overlap  = 0;

  qspi_ram_responder #(.ADDRESS_WIDTH(AW), .DUMMY_NIBBLES(DN)) dut (
    .clock(clock), .reset(reset), .qspi_clk(qspi_clk), .qspi_select(qspi_select),
    .qspi_data_in(qspi_data_in), .qspi_data_out(qspi_data_out), .qspi_data_oe(qspi_data_oe),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .cmd_error(cmd_error)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: read data appears the clock after the strobe.
  always @(posedge clock) begin
    if (mem_re) mem_rdata <= store[mem_addr];
    if (mem_we) store[mem_addr] <= mem_wdata;
  end

  always @(negedge clock) begin
    if (mem_re) re_q.push_back(mem_addr);
    if (mem_we) begin
      we_addr_q.push_back(mem_addr);
      we_dat_q.push_back(mem_wdata);
    end
    if (cmd_error) err_cnt++;
    if (qspi_data_oe) oe_cnt++;
    if (mem_re && mem_we) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nib(input logic [3:0] d, output logic [3:0] q, output logic o);
    qspi_data_in = d;
    repeat (HALF) @(negedge clock);
    q = qspi_data_out;
    o = qspi_data_oe;
    qspi_clk = 1'b1;
    repeat (HALF) @(negedge clock);
    qspi_clk = 1'b0;
  endtask

  task automatic start(input logic [7:0] cmd, input logic [23:0] a);
    logic [3:0] q;
    logic       o;
    qspi_select = 1'b0;
    repeat (4) @(negedge clock);
    nib(cmd[7:4], q, o);
    nib(cmd[3:0], q, o);
    for (int i = 5; i >= 0; i--) nib(a[4*i +: 4], q, o);
  endtask

  task automatic end_txn();
    repeat (3) @(negedge clock);
    qspi_select = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic write_txn(input string tag, input logic [AW-1:0] a, input byte_q_t bytes);
    logic [3:0] q;
    logic       o;
    int we_base = we_addr_q.size();
    int oe_base = oe_cnt;
    int n = bytes.size();
    int got_n;
    logic [AW-1:0] ak;
    start(8'h02, 24'(a));
    for (int k = 0; k < n; k++) begin
      nib(bytes[k][7:4], q, o);
      nib(bytes[k][3:0], q, o);
      ak = a + AW'(k);
      ref_mem[ak] = bytes[k];
    end
    end_txn();
    got_n = we_addr_q.size() - we_base;
    check({tag, " we count"}, got_n, n);
    check({tag, " oe stays low"}, oe_cnt - oe_base, 0);
    for (int k = 0; k < n && k < got_n; k++) begin
      ak = a + AW'(k);
      check({tag, " we addr"}, we_addr_q[we_base + k], ak);
      check({tag, " we data"}, we_dat_q[we_base + k], bytes[k]);
    end
  endtask

  task automatic read_txn(input string tag, input logic [AW-1:0] a, input int n);
    logic [3:0] q;
    logic       o;
    int re_base = re_q.size();
    int dummy_oe = 0;
    int data_oe = 0;
    logic [AW-1:0] ak;
    start(8'h0B, 24'(a));
    for (int i = 0; i < DN; i++) begin
      nib(4'($urandom), q, o);
      dummy_oe += int'(o);
    end
    check({tag, " oe low in dummy"}, dummy_oe, 0);
    for (int k = 0; k < n; k++) begin
      ak = a + AW'(k);
      nib(4'($urandom), q, o);
      data_oe += int'(o);
      check({tag, " hi nibble"}, q, ref_mem[ak][7:4]);
      nib(4'($urandom), q, o);
      data_oe += int'(o);
      check({tag, " lo nibble"}, q, ref_mem[ak][3:0]);
    end
    check({tag, " oe high in data"}, data_oe, 2 * n);
    end_txn();
    check({tag, " oe low after"}, qspi_data_oe, 1'b0);
    check({tag, " re issued"}, (re_q.size() - re_base) >= n, 1'b1);
    for (int k = 0; k < n && k < 2 && re_base + k < re_q.size(); k++) begin
      ak = a + AW'(k);
      check({tag, " re addr"}, re_q[re_base + k], ak);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data_out"}, qspi_data_out, 4'h0);
    check({tag, " oe"}, qspi_data_oe, 1'b0);
    check({tag, " mem_addr"}, mem_addr, '0);
    check({tag, " mem_re"}, mem_re, 1'b0);
    check({tag, " mem_we"}, mem_we, 1'b0);
    check({tag, " mem_wdata"}, mem_wdata, 8'h00);
    check({tag, " cmd_error"}, cmd_error, 1'b0);
  endtask

  initial begin
    logic [3:0] q;
    logic       o;
    int base_e, base_re, base_we, base_oe;
    logic [AW-1:0] ra;
    byte_q_t bq;

    reset = 1'b1;
    qspi_clk = 1'b0;
    qspi_select = 1'b1;
    qspi_data_in = 4'h0;
    repeat (4) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check_reset_outputs("post reset");

    // Basic write then read-back of the same two bytes.
    bq = '{8'hA5, 8'h3C};
    base_e = err_cnt;
    write_txn("write", 16'h0010, bq);
    check("write no cmd_error", err_cnt - base_e, 0);
    read_txn("read", 16'h0010, 2);

    // Address wrap across the top of the 16-bit space.
    bq = '{8'h5A, 8'hC3};
    write_txn("wrap write", 16'hFFFF, bq);
    read_txn("wrap read", 16'hFFFF, 2);

    // Unsupported command followed by ten ignored clocks.
    base_e = err_cnt; base_re = re_q.size(); base_we = we_addr_q.size(); base_oe = oe_cnt;
    start(8'h9F, 24'h000010);
    for (int i = 0; i < 10; i++) nib(4'($urandom), q, o);
    end_txn();
    check("bad cmd error pulses", err_cnt - base_e, 1);
    check("bad cmd oe", oe_cnt - base_oe, 0);
    check("bad cmd re", re_q.size() - base_re, 0);
    check("bad cmd we", we_addr_q.size() - base_we, 0);
    read_txn("after bad cmd", 16'h0010, 2);

    // Select raised after a single write nibble.
    base_we = we_addr_q.size();
    start(8'h02, 24'h000200);
    nib(4'h7, q, o);
    end_txn();
    check("abort write we", we_addr_q.size() - base_we, 0);

    // Select raised in the middle of the read data phase.
    start(8'h0B, 24'h000010);
    for (int i = 0; i < DN + 1; i++) nib(4'h0, q, o);
    check("abort read oe before", qspi_data_oe, 1'b1);
    qspi_select = 1'b1;
    repeat (4) @(negedge clock);
    check("abort read oe cleared", qspi_data_oe, 1'b0);
    repeat (8) @(negedge clock);

    // Reset in the middle of a read.
    start(8'h0B, 24'h000010);
    for (int i = 0; i < DN + 1; i++) nib(4'h0, q, o);
    check("reset read oe before", qspi_data_oe, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid-read reset");
    base_re = re_q.size(); base_we = we_addr_q.size();
    qspi_select = 1'b1;
    repeat (6) @(negedge clock);
    check("reset no re", re_q.size() - base_re, 0);
    check("reset no we", we_addr_q.size() - base_we, 0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    read_txn("after reset", 16'h0011, 1);

    // Random write/read-back pairs, biased toward the top of memory to exercise wrap.
    for (int t = 0; t < 6; t++) begin
      int n;
      ra = ($urandom_range(0, 1) == 1) ? AW'(16'hFFFF - 16'($urandom_range(0, 2))) : AW'($urandom);
      n = $urandom_range(1, 4);
      bq.delete();
      for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
      write_txn("rand write", ra, bq);
      read_txn("rand read", ra, n);
    end

    check("re/we overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
